// File: rtl/mogol_pkg.sv
// Shared definitions for the mogol_bahis automated bettor: FSM states, horse
// codes, datapath widths and the helpers that cut race fields out of the
// 16-bit LFSR word.
//
// Race field layout: every race output is a window of the LFSR word taken
// circularly, starting at a fixed bit offset. Bit i of a field is
// lfsr[(offset + i) mod 16]. The offsets are listed below.
package mogol_pkg;

  localparam int HIZ_W     = 10;
  localparam int SEYIRCI_W = 3;
  localparam int PARA_W    = 7;
  localparam int BAKIYE_W  = 14;
  localparam int FARK_W    = BAKIYE_W + 1;
  localparam int LFSR_W    = 16;
  localparam int TUR_W     = 8;

  localparam logic [PARA_W-1:0] PARA_MAX = 7'd127;
  localparam logic [TUR_W-1:0]  TUR_MAX  = 8'd255;

  // Circular window offsets into the LFSR word for each race output.
  localparam int HIZ_OFS_BEYAZ       = 0;
  localparam int HIZ_OFS_SIYAH       = 5;
  localparam int HIZ_OFS_BOZ         = 10;
  localparam int JOKEY_OFS_BEYAZ     = 3;
  localparam int JOKEY_OFS_SIYAH     = 8;
  localparam int JOKEY_OFS_BOZ       = 13;
  localparam int SEYIRCI_OFS_BEYAZ   = 0;
  localparam int SEYIRCI_OFS_SIYAH   = 4;
  localparam int SEYIRCI_OFS_BOZ     = 8;

  typedef enum logic [2:0] {
    BASLA,
    BAHIS,
    BEKLE,
    DEGERLENDIR,
    BITTI
  } durum_e;

  typedef enum logic [1:0] {
    AT_YOK   = 2'd0,
    AT_BEYAZ = 2'd1,
    AT_SIYAH = 2'd2,
    AT_BOZ   = 2'd3
  } at_e;

  // 10-bit circular window of the LFSR word starting at bit ofs.
  function automatic logic [HIZ_W-1:0] hiz_dilimi(input logic [LFSR_W-1:0] l,
                                                  input int ofs);
    logic [2*LFSR_W-1:0] cift;
    cift = {l, l} >> ofs;
    return cift[HIZ_W-1:0];
  endfunction

  // 3-bit circular window of the LFSR word starting at bit ofs.
  function automatic logic [SEYIRCI_W-1:0] seyirci_dilimi(input logic [LFSR_W-1:0] l,
                                                          input int ofs);
    logic [2*LFSR_W-1:0] cift;
    cift = {l, l} >> ofs;
    return cift[SEYIRCI_W-1:0];
  endfunction

endpackage

// File: rtl/mogol_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (x^16 + x^14 + x^13 + x^11 + 1).
// Shifts left; the feedback bit enters at bit 0. Advances only when en_i is
// high. A seed of zero would lock the register, so it is replaced by 1.
module mogol_lfsr16
  import mogol_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TOHUM = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic [LFSR_W-1:0] deger_o
);

  localparam logic [LFSR_W-1:0] BASLANGIC = (TOHUM == '0) ? 16'h0001 : TOHUM;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              geri_besleme;

  // Next value: XOR of the tap bits shifted in at the bottom.
  always_comb begin
    geri_besleme = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d       = en_i ? {lfsr_q[LFSR_W-2:0], geri_besleme} : lfsr_q;
  end

  // State register, reseeded by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= BASLANGIC;
    else         lfsr_q <= lfsr_d;
  end

  assign deger_o = lfsr_q;

endmodule

// File: rtl/mogol_bahis_oyuncu.sv
// Automated martingale bettor for mogol_bahis. Each round it places one bet
// for a single cycle, waits SONUC_GECIKME cycles, then compares the returned
// bakiye with the value before the bet: double after a loss (saturating at
// 127), back to TABAN_PARA after a win, unchanged on a draw. The game ends on
// the profit target, the stop-loss or the round limit. Race parameters are
// windows of an internal LFSR that advances once per round.
//
// Build option: define RASTGELE_AT_EN to choose the horse from LFSR[1:0]
// (code 0 folds onto boz); otherwise horses rotate beyaz -> siyah -> boz.
module mogol_bahis_oyuncu
  import mogol_pkg::*;
#(
  parameter int                          TABAN_PARA    = 10,
  parameter int                          SONUC_GECIKME = 1,
  parameter logic signed [BAKIYE_W-1:0]  HEDEF         = 14'sd1000,
  parameter logic signed [BAKIYE_W-1:0]  ZARAR_SINIRI  = -14'sd1000,
  parameter int                          TUR_SAYISI    = 64,
  parameter logic [LFSR_W-1:0]           LFSR_TOHUM    = 16'hACE1
) (
  input  logic                        saat,
  input  logic                        reset,
  input  logic signed [BAKIYE_W-1:0]  bakiye,
  output logic [HIZ_W-1:0]            beyaz_at_hizlar,
  output logic [HIZ_W-1:0]            siyah_at_hizlar,
  output logic [HIZ_W-1:0]            boz_at_hizlar,
  output logic [HIZ_W-1:0]            beyaz_jokey_komutlar,
  output logic [HIZ_W-1:0]            siyah_jokey_komutlar,
  output logic [HIZ_W-1:0]            boz_jokey_komutlar,
  output logic [SEYIRCI_W-1:0]        beyaz_at_seyirci,
  output logic [SEYIRCI_W-1:0]        siyah_at_seyirci,
  output logic [SEYIRCI_W-1:0]        boz_at_seyirci,
  output logic [1:0]                  tahmin_edilen_at,
  output logic [PARA_W-1:0]           yatirilan_para,
  output logic [TUR_W-1:0]            tur,
  output logic                        oyun_bitti
);

  localparam logic [PARA_W-1:0] TABAN_BET   = PARA_W'(TABAN_PARA);
  localparam logic [3:0]        GECIKME_SON = 4'(SONUC_GECIKME - 1);
  localparam logic [TUR_W-1:0]  TUR_SINIR   = TUR_W'(TUR_SAYISI);

  // Doubling after a loss; anything that would pass 127 sticks at 127.
  function automatic logic [PARA_W-1:0] ikiye_katla(input logic [PARA_W-1:0] b);
    logic [PARA_W:0] iki;
    iki = {b, 1'b0};
    return iki[PARA_W] ? PARA_MAX : iki[PARA_W-1:0];
  endfunction

  // Round counter increment that holds at 255.
  function automatic logic [TUR_W-1:0] tur_arttir(input logic [TUR_W-1:0] t);
    return (t == TUR_MAX) ? t : t + 8'd1;
  endfunction

  // Round-robin successor: beyaz -> siyah -> boz -> beyaz.
  function automatic at_e sonraki_at(input at_e a);
    case (a)
      AT_BEYAZ: return AT_SIYAH;
      AT_SIYAH: return AT_BOZ;
      default:  return AT_BEYAZ;
    endcase
  endfunction

  durum_e                       durum_q;
  logic [PARA_W-1:0]            bet_q;
  logic signed [BAKIYE_W-1:0]   onceki_q;
  logic [3:0]                   bekle_q;
  logic [TUR_W-1:0]             tur_q;
  at_e                          rr_q;
  at_e                          tahmin_q;
  logic [PARA_W-1:0]            para_q;
  logic                         bitti_q;
  logic [2:0][HIZ_W-1:0]        hiz_q;
  logic [2:0][HIZ_W-1:0]        jokey_q;
  logic [2:0][SEYIRCI_W-1:0]    seyirci_q;

  logic [LFSR_W-1:0]            lfsr_deger;
  logic                         lfsr_en;
  logic signed [FARK_W-1:0]     bakiye_gen;
  logic signed [FARK_W-1:0]     onceki_gen;
  logic signed [FARK_W-1:0]     fark;
  logic [PARA_W-1:0]            bet_yeni;
  logic [PARA_W-1:0]            bet_icin;
  logic [TUR_W-1:0]             tur_yeni;
  logic                         dur;
  logic                         bahise_gec;
  at_e                          secilen_at;
  logic [2:0][HIZ_W-1:0]        hiz_yeni;
  logic [2:0][HIZ_W-1:0]        jokey_yeni;
  logic [2:0][SEYIRCI_W-1:0]    seyirci_yeni;

  // The LFSR steps exactly once per round, on leaving BAHIS.
  assign lfsr_en = (durum_q == BAHIS);

  mogol_lfsr16 #(
    .TOHUM   (LFSR_TOHUM)
  ) u_lfsr (
    .clk_i   (saat),
    .rst_ni  (reset),
    .en_i    (lfsr_en),
    .deger_o (lfsr_deger)
  );

  // Round evaluation: signed balance difference, next bet, next round count
  // and the stop decision, all from the bakiye seen in DEGERLENDIR.
  always_comb begin
    bakiye_gen = {bakiye[BAKIYE_W-1], bakiye};
    onceki_gen = {onceki_q[BAKIYE_W-1], onceki_q};
    fark       = bakiye_gen - onceki_gen;
    if (fark < 0)      bet_yeni = ikiye_katla(bet_q);
    else if (fark > 0) bet_yeni = TABAN_BET;
    else               bet_yeni = bet_q;
    tur_yeni = tur_arttir(tur_q);
    dur      = (bakiye >= HEDEF) || (bakiye <= ZARAR_SINIRI) || (tur_yeni == TUR_SINIR);
  end

  // Race fields for the coming bet, cut from the current LFSR word.
  always_comb begin
    hiz_yeni[0]     = hiz_dilimi(lfsr_deger, HIZ_OFS_BEYAZ);
    hiz_yeni[1]     = hiz_dilimi(lfsr_deger, HIZ_OFS_SIYAH);
    hiz_yeni[2]     = hiz_dilimi(lfsr_deger, HIZ_OFS_BOZ);
    jokey_yeni[0]   = hiz_dilimi(lfsr_deger, JOKEY_OFS_BEYAZ);
    jokey_yeni[1]   = hiz_dilimi(lfsr_deger, JOKEY_OFS_SIYAH);
    jokey_yeni[2]   = hiz_dilimi(lfsr_deger, JOKEY_OFS_BOZ);
    seyirci_yeni[0] = seyirci_dilimi(lfsr_deger, SEYIRCI_OFS_BEYAZ);
    seyirci_yeni[1] = seyirci_dilimi(lfsr_deger, SEYIRCI_OFS_SIYAH);
    seyirci_yeni[2] = seyirci_dilimi(lfsr_deger, SEYIRCI_OFS_BOZ);
  end

`ifdef RASTGELE_AT_EN
  // LFSR-driven pick; the 2-bit code 0 is not a horse, so it folds onto boz.
  always_comb begin
    secilen_at = at_e'(lfsr_deger[1:0]);
    if (lfsr_deger[1:0] == 2'b00) secilen_at = AT_BOZ;
  end
`else
  // Round-robin pick held in rr_q.
  always_comb secilen_at = rr_q;
`endif

  // A bet is loaded on every edge that lands in BAHIS; coming from
  // DEGERLENDIR it must already carry the freshly updated bet.
  always_comb begin
    bahise_gec = (durum_q == BASLA) || ((durum_q == DEGERLENDIR) && !dur);
    bet_icin   = (durum_q == DEGERLENDIR) ? bet_yeni : bet_q;
  end

  // Game FSM with registered outputs.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q   <= BASLA;
      bet_q     <= TABAN_BET;
      onceki_q  <= '0;
      bekle_q   <= '0;
      tur_q     <= '0;
      rr_q      <= AT_BEYAZ;
      tahmin_q  <= AT_YOK;
      para_q    <= '0;
      bitti_q   <= 1'b0;
      hiz_q     <= '0;
      jokey_q   <= '0;
      seyirci_q <= '0;
    end else begin
      case (durum_q)
        BASLA: begin
          onceki_q <= bakiye;
          durum_q  <= BAHIS;
        end
        BAHIS: begin
          tahmin_q <= AT_YOK;
          para_q   <= '0;
          bekle_q  <= '0;
          durum_q  <= BEKLE;
        end
        BEKLE: begin
          if (bekle_q == GECIKME_SON) begin
            bekle_q <= '0;
            durum_q <= DEGERLENDIR;
          end else begin
            bekle_q <= bekle_q + 4'd1;
          end
        end
        DEGERLENDIR: begin
          bet_q    <= bet_yeni;
          tur_q    <= tur_yeni;
          onceki_q <= bakiye;
          if (dur) begin
            durum_q   <= BITTI;
            bitti_q   <= 1'b1;
            hiz_q     <= '0;
            jokey_q   <= '0;
            seyirci_q <= '0;
          end else begin
            durum_q <= BAHIS;
          end
        end
        BITTI: begin
          durum_q <= BITTI;
        end
        default: begin
          durum_q <= BASLA;
        end
      endcase

      if (bahise_gec) begin
        tahmin_q  <= secilen_at;
        para_q    <= bet_icin;
        rr_q      <= sonraki_at(rr_q);
        hiz_q     <= hiz_yeni;
        jokey_q   <= jokey_yeni;
        seyirci_q <= seyirci_yeni;
      end
    end
  end

  assign beyaz_at_hizlar      = hiz_q[0];
  assign siyah_at_hizlar      = hiz_q[1];
  assign boz_at_hizlar        = hiz_q[2];
  assign beyaz_jokey_komutlar = jokey_q[0];
  assign siyah_jokey_komutlar = jokey_q[1];
  assign boz_jokey_komutlar   = jokey_q[2];
  assign beyaz_at_seyirci     = seyirci_q[0];
  assign siyah_at_seyirci     = seyirci_q[1];
  assign boz_at_seyirci       = seyirci_q[2];
  assign tahmin_edilen_at     = tahmin_q;
  assign yatirilan_para       = para_q;
  assign tur                  = tur_q;
  assign oyun_bitti           = bitti_q;

endmodule

// File: tb/tb_mogol_bahis_oyuncu.sv
// Bench for mogol_bahis_oyuncu: a round-level game model checked against the
// DUT every cycle, plus directed scenarios with literal expectations.
module tb_mogol_bahis_oyuncu;

  localparam int          TABAN   = 10;
  localparam int          GEC     = 1;
  localparam int          HEDEF_V = 1000;
  localparam int          ZARAR_V = -1000;
  localparam int          TURS    = 64;
  localparam logic [15:0] TOHUM   = 16'hACE1;

  logic               saat = 1'b0;
  logic               reset;
  logic signed [13:0] bakiye;
  logic [9:0]         bh, sh, zh, bj, sj, zj;
  logic [2:0]         bs, ss, zs;
  logic [1:0]         tahmin;
  logic [6:0]         para;
  logic [7:0]         tur;
  logic               bitti;

  int n_cmp = 0;
  int n_err = 0;

  always #5 saat = ~saat;

  mogol_bahis_oyuncu #(
    .TABAN_PARA    (TABAN),
    .SONUC_GECIKME (GEC),
    .HEDEF         (14'sd1000),
    .ZARAR_SINIRI  (-14'sd1000),
    .TUR_SAYISI    (TURS),
    .LFSR_TOHUM    (TOHUM)
  ) dut (
    .saat                 (saat),
    .reset                (reset),
    .bakiye               (bakiye),
    .beyaz_at_hizlar      (bh),
    .siyah_at_hizlar      (sh),
    .boz_at_hizlar        (zh),
    .beyaz_jokey_komutlar (bj),
    .siyah_jokey_komutlar (sj),
    .boz_jokey_komutlar   (zj),
    .beyaz_at_seyirci     (bs),
    .siyah_at_seyirci     (ss),
    .boz_at_seyirci       (zs),
    .tahmin_edilen_at     (tahmin),
    .yatirilan_para       (para),
    .tur                  (tur),
    .oyun_bitti           (bitti)
  );

  task automatic chk(input string ad, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", ad, got, exp, $time);
    end
  endtask

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, new bit enters at bit 0.
  function automatic logic [15:0] lfsr_ileri(input logic [15:0] s);
    int   musluk [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (musluk[k]) fb = fb ^ s[musluk[k]-1];
    return {s[14:0], fb};
  endfunction

  // Circular window of width w starting at bit ofs.
  function automatic int alan(input logic [15:0] s, input int ofs, input int w);
    int v = 0;
    for (int i = 0; i < w; i++)
      if (s[(ofs + i) % 16]) v = v | (1 << i);
    return v;
  endfunction

  // ---------------- round-level game model ----------------
  int          cyc    = 0;   // rising edges since reset release
  bit          m_done = 0;
  int          m_bet  = TABAN;
  int          m_prev = 0;
  int          m_tur  = 0;   // completed rounds == index of current round
  logic [15:0] m_lfsr = TOHUM;

  task automatic model_sifirla();
    cyc = 0; m_done = 0; m_bet = TABAN; m_prev = 0; m_tur = 0; m_lfsr = TOHUM;
  endtask

  task automatic model_tur_sonu(input int b);
    int fark;
    fark = b - m_prev;
    if (fark < 0)      m_bet = (2 * m_bet > 127) ? 127 : 2 * m_bet;
    else if (fark > 0) m_bet = TABAN;
    m_prev = b;
    m_tur  = (m_tur < 255) ? m_tur + 1 : 255;
    m_lfsr = lfsr_ileri(m_lfsr);
    if (b >= HEDEF_V || b <= ZARAR_V || m_tur == TURS) m_done = 1;
  endtask

  always @(posedge saat or negedge reset) begin
    if (!reset) model_sifirla();
    else begin
      cyc++;
      if (!m_done && cyc == 1)                        m_prev = int'(bakiye);
      else if (!m_done && ((cyc - 1) % (GEC + 2)) == 0) model_tur_sonu(int'(bakiye));
    end
  end

  // ---------------- per-cycle compare ----------------
  int          e_tah, e_para, ph;
  bit          yaris;
  logic [15:0] e_l;

  function automatic int beklenen_alan(input bit on, input logic [15:0] l,
                                       input int ofs, input int w);
    return on ? alan(l, ofs, w) : 0;
  endfunction

  always @(negedge saat) begin
    e_tah = 0; e_para = 0; yaris = 0; e_l = '0;
    if (reset !== 1'b1 || cyc == 0) begin
      chk("tur", int'(tur), 0);
      chk("oyun_bitti", int'(bitti), 0);
    end else if (m_done) begin
      chk("tur", int'(tur), m_tur);
      chk("oyun_bitti", int'(bitti), 1);
    end else begin
      ph    = (cyc - 1) % (GEC + 2);
      yaris = 1;
      e_l   = m_lfsr;
      if (ph == 0) begin
        e_para = m_bet;
`ifdef RASTGELE_AT_EN
        e_tah = (m_lfsr[1:0] == 2'b00) ? 3 : int'(m_lfsr[1:0]);
`else
        e_tah = (m_tur % 3) + 1;
`endif
      end
      chk("tur", int'(tur), m_tur);
      chk("oyun_bitti", int'(bitti), 0);
    end
    chk("tahmin", int'(tahmin), e_tah);
    chk("para", int'(para), e_para);
    chk("beyaz_hiz", int'(bh), beklenen_alan(yaris, e_l, 0, 10));
    chk("siyah_hiz", int'(sh), beklenen_alan(yaris, e_l, 5, 10));
    chk("boz_hiz", int'(zh), beklenen_alan(yaris, e_l, 10, 10));
    chk("beyaz_jokey", int'(bj), beklenen_alan(yaris, e_l, 3, 10));
    chk("siyah_jokey", int'(sj), beklenen_alan(yaris, e_l, 8, 10));
    chk("boz_jokey", int'(zj), beklenen_alan(yaris, e_l, 13, 10));
    chk("beyaz_seyirci", int'(bs), beklenen_alan(yaris, e_l, 0, 3));
    chk("siyah_seyirci", int'(ss), beklenen_alan(yaris, e_l, 4, 3));
    chk("boz_seyirci", int'(zs), beklenen_alan(yaris, e_l, 8, 3));
  end

  // ---------------- directed stimulus ----------------
  task automatic sifirla();
    #2 reset = 1'b0;
    bakiye = '0;
    repeat (2) @(negedge saat);
    #2 reset = 1'b1;
  endtask

  task automatic wait_bahis(input string ad);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge saat);
      if (tahmin != 2'd0) ok = 1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: no bet within 50 cycles, one required", ad);
    end
  endtask

  int  para_a [6];
  int  at_a   [6];
  int  cyc_a  [6];
  int  n_bet, bitis, bak_i, sifir_disi;
  bit  goruldu;
  int  t1_at  [4] = '{1, 2, 3, 1};
  int  t2_bek [6] = '{10, 20, 40, 80, 127, 127};

  initial begin
    reset  = 1'b1;
    bakiye = '0;

    // 1) flat balance: 64 rounds of base bets, 3 cycles apart
    sifirla();
    n_bet = 0; bitis = 0; goruldu = 0;
    for (int i = 0; i < 400 && !goruldu; i++) begin
      @(negedge saat);
      if (tahmin != 2'd0) begin
        if (n_bet < 6) begin
          para_a[n_bet] = int'(para); at_a[n_bet] = int'(tahmin); cyc_a[n_bet] = i;
        end
        n_bet++;
      end
      if (bitti) begin goruldu = 1; bitis = i + 1; end
    end
    chk("t1_bitti_goruldu", int'(goruldu), 1);
    chk("t1_bitis_cevrimi", bitis, 1 + 64 * 3);
    chk("t1_tur", int'(tur), 64);
    chk("t1_bahis_sayisi", n_bet, 64);
    chk("t1_ilk_bahis", para_a[0], 10);
    chk("t1_aralik", cyc_a[1] - cyc_a[0], 3);
    chk("t1_aralik2", cyc_a[2] - cyc_a[1], 3);
`ifndef RASTGELE_AT_EN
    for (int j = 0; j < 4; j++) chk($sformatf("t1_at%0d", j), at_a[j], t1_at[j]);
`endif

    // 2) every bet lost: doubling to saturation, stop-loss at round 11
    sifirla();
    n_bet = 0; bitis = 0; goruldu = 0; bak_i = 0;
    for (int i = 0; i < 200 && !goruldu; i++) begin
      @(negedge saat);
      if (tahmin != 2'd0) begin
        if (n_bet < 6) para_a[n_bet] = int'(para);
        n_bet++;
        bak_i  = bak_i - int'(para);
        bakiye = 14'(bak_i);
      end
      if (bitti) begin goruldu = 1; bitis = i + 1; end
    end
    chk("t2_bitti_goruldu", int'(goruldu), 1);
    chk("t2_bitis_cevrimi", bitis, 34);
    chk("t2_tur", int'(tur), 11);
    chk("t2_bahis_sayisi", n_bet, 11);
    for (int j = 0; j < 6; j++) chk($sformatf("t2_bahis%0d", j), para_a[j], t2_bek[j]);

    // 3) loss, then win, then draw
    sifirla();
    wait_bahis("t3_r0"); chk("t3_bahis0", int'(para), 10); bakiye = -14'sd10;
    wait_bahis("t3_r1"); chk("t3_bahis1", int'(para), 20); bakiye = 14'sd30;
    wait_bahis("t3_r2"); chk("t3_bahis2", int'(para), 10);
    wait_bahis("t3_r3"); chk("t3_bahis3", int'(para), 10);

    // 4) target reached during the first wait
    sifirla();
    wait_bahis("t4_r0");
    chk("t4_bahis0", int'(para), 10);
    @(negedge saat);
    bakiye = 14'sd1000;
    repeat (2) @(negedge saat);
    chk("t4_bitti", int'(bitti), 1);
    chk("t4_tur", int'(tur), 1);
    sifir_disi = 0;
    repeat (10) begin
      @(negedge saat);
      if (tahmin != 2'd0 || para != 7'd0) sifir_disi++;
    end
    chk("t4_bitti_sonrasi_bahis", sifir_disi, 0);

    // 5) asynchronous reset in the wait of round 3
    sifirla();
    wait_bahis("t5_r0"); bakiye = -14'sd10;
    wait_bahis("t5_r1"); bakiye = -14'sd30;
    wait_bahis("t5_r2"); chk("t5_bahis2", int'(para), 40);
    @(negedge saat);
    chk("t5_tur_once", int'(tur), 2);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_tur", int'(tur), 0);
    chk("t5_async_hiz", int'(bh), 0);
    chk("t5_async_seyirci", int'(zs), 0);
    @(negedge saat);
    bakiye = '0;
    #2 reset = 1'b1;
    wait_bahis("t5_yeniden");
    chk("t5_bahis", int'(para), 10);
    chk("t5_at", int'(tahmin), 1);
    chk("t5_beyaz_hiz_tohum", int'(bh), 'h0E1);

    @(negedge saat);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
